// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch state encoding and source-count encodings
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   // Fetch sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE1 = 3'd1,
      ISSUE2 = 3'd2,
      LAST   = 3'd3,
      RESP   = 3'd4
   } fetch_state_t;

   // Number-of-sources encodings
   localparam logic [1:0] NSRC_0 = 2'd0;
   localparam logic [1:0] NSRC_1 = 2'd1;
   localparam logic [1:0] NSRC_2 = 2'd2;
   localparam logic [1:0] NSRC_3 = 2'd3;

   // A request for three sources is serviced as two
   function automatic logic [1:0] norm_nsrc(input logic [1:0] nsrc);
      return (nsrc == NSRC_3) ? NSRC_2 : nsrc;
   endfunction

endpackage

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - sequences up to two source reads through a single regfile read port
// Optional writeback bypass into captured/held operands: OPERAND_FETCH_WB_BYPASS_EN
module operand_fetch #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_nsrc,
   input  logic [ADDR_W-1:0] req_src1,
   input  logic [ADDR_W-1:0] req_src2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_op1,
   output logic [DATA_W-1:0] rsp_op2,
   output logic              rf_read_enable,
   output logic [ADDR_W-1:0] rf_read_addr,
   input  logic [DATA_W-1:0] rf_read_data,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_write_enable,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data
);

   import cpu_pkg::*;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] src1_q, src2_q;
   logic [1:0]        nsrc_q;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] op2_q, op2_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              accept;

   // Writeback forwarding: a matching write wins over the fallback value
   function automatic logic [DATA_W-1:0] pick_operand(
      input logic              hit_en,
      input logic              wb_v,
      input logic [ADDR_W-1:0] wb_a,
      input logic [DATA_W-1:0] wb_d,
      input logic [ADDR_W-1:0] src,
      input logic [DATA_W-1:0] fallback
   );
      if (hit_en && wb_v && (wb_a == src)) begin
         return wb_d;
      end
      return fallback;
   endfunction

   assign accept = req_valid && req_ready;

   // The write port is a straight pass-through from writeback
   assign rf_write_enable = wb_valid;
   assign rf_write_addr   = wb_addr;
   assign rf_write_data   = wb_data;

   assign rsp_op1 = op1_q;
   assign rsp_op2 = op2_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and read-port / handshake decode
   always_comb begin
      state_d        = state_q;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      rf_read_enable = 1'b0;
      rf_read_addr   = rd_addr_q;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = (norm_nsrc(req_nsrc) == NSRC_0) ? RESP : ISSUE1;
            end
         end
         ISSUE1: begin
            rf_read_enable = 1'b1;
            rf_read_addr   = src1_q;
            state_d        = (nsrc_q == NSRC_2) ? ISSUE2 : LAST;
         end
         ISSUE2: begin
            rf_read_enable = 1'b1;
            rf_read_addr   = src2_q;
            state_d        = LAST;
         end
         LAST: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture: cleared on accept, loaded one cycle after each read strobe
   always_comb begin
      op1_d = op1_q;
      op2_d = op2_q;
      if (accept) begin
         op1_d = '0;
         op2_d = '0;
      end
      case (state_q)
         ISSUE2: begin
            op1_d = pick_operand(BYPASS_EN, wb_valid, wb_addr, wb_data, src1_q, rf_read_data);
         end
         LAST: begin
            if (nsrc_q == NSRC_2) begin
               op2_d = pick_operand(BYPASS_EN, wb_valid, wb_addr, wb_data, src2_q, rf_read_data);
            end else begin
               op1_d = pick_operand(BYPASS_EN, wb_valid, wb_addr, wb_data, src1_q, rf_read_data);
            end
         end
         RESP: begin
            // Held operands track later writes to their source registers
            if (nsrc_q != NSRC_0) begin
               op1_d = pick_operand(BYPASS_EN, wb_valid, wb_addr, wb_data, src1_q, op1_q);
            end
            if (nsrc_q == NSRC_2) begin
               op2_d = pick_operand(BYPASS_EN, wb_valid, wb_addr, wb_data, src2_q, op2_q);
            end
         end
         default: begin
         end
      endcase
   end

   // Request latch, operand registers and sticky read address
   always_ff @(posedge clk) begin
      if (rst) begin
         src1_q    <= '0;
         src2_q    <= '0;
         nsrc_q    <= NSRC_0;
         op1_q     <= '0;
         op2_q     <= '0;
         rd_addr_q <= '0;
      end else begin
         if (accept) begin
            src1_q <= req_src1;
            src2_q <= req_src2;
            nsrc_q <= norm_nsrc(req_nsrc);
         end
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         rd_addr_q <= rf_read_addr;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
   localparam logic [15:0] EXP_BYP_CAPTURE = 16'h00AA;
   localparam logic [15:0] EXP_BYP_HOLD    = 16'h0055;
`else
   localparam logic [15:0] EXP_BYP_CAPTURE = 16'h1234;
   localparam logic [15:0] EXP_BYP_HOLD    = 16'h1234;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_nsrc;
   logic [ADDR_W-1:0] req_src1, req_src2;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_op1, rsp_op2;
   logic              rf_read_enable;
   logic [ADDR_W-1:0] rf_read_addr;
   logic [DATA_W-1:0] rf_read_data;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              rf_write_enable;
   logic [ADDR_W-1:0] rf_write_addr;
   logic [DATA_W-1:0] rf_write_data;

   int n_cmp  = 0;
   int n_fail = 0;
   int strobes = 0;
   int rsp_seen = 0;
   int base;

   logic [DATA_W-1:0] mem [0:7];

   operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_nsrc(req_nsrc),
      .req_src1(req_src1), .req_src2(req_src2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
      .rf_read_enable(rf_read_enable), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
   );

   always #5 clk = ~clk;

   // Regfile model: one-cycle read latency, written from the write port
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
         mem[3] <= 16'h1234;
         mem[5] <= 16'hBEEF;
         rf_read_data <= '0;
      end else begin
         if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
         if (rf_read_enable) rf_read_data <= mem[rf_read_addr];
      end
   end

   // Event counters for strobes and responses
   always @(posedge clk) begin
      if (rf_read_enable === 1'b1) strobes <= strobes + 1;
      if (rsp_valid === 1'b1) rsp_seen <= rsp_seen + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [1:0] nsrc, input logic [2:0] s1, input logic [2:0] s2);
      req_valid = 1'b1;
      req_nsrc  = nsrc;
      req_src1  = s1;
      req_src2  = s2;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_nsrc = 2'd0; req_src1 = '0; req_src2 = '0;
      rsp_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      step(); step();
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_op1", 32'(rsp_op1), 32'd0);
      check("reset_op2", 32'(rsp_op2), 32'd0);
      check("reset_rd_en", 32'(rf_read_enable), 32'd0);
      check("reset_rd_addr", 32'(rf_read_addr), 32'd0);
      rst = 1'b0;
      step();
      check("idle_req_ready", 32'(req_ready), 32'd1);

      // Two sources: reads 3 then 5, response in the fourth cycle
      rsp_ready = 1'b1;
      base = strobes;
      request(2'd2, 3'd3, 3'd5);
      check("n2_issue1_en", 32'(rf_read_enable), 32'd1);
      check("n2_issue1_addr", 32'(rf_read_addr), 32'd3);
      check("n2_busy_ready", 32'(req_ready), 32'd0);
      check("n2_c1_valid", 32'(rsp_valid), 32'd0);
      step();
      check("n2_issue2_en", 32'(rf_read_enable), 32'd1);
      check("n2_issue2_addr", 32'(rf_read_addr), 32'd5);
      step();
      check("n2_last_en", 32'(rf_read_enable), 32'd0);
      check("n2_last_addr_hold", 32'(rf_read_addr), 32'd5);
      check("n2_c3_valid", 32'(rsp_valid), 32'd0);
      step();
      check("n2_c4_valid", 32'(rsp_valid), 32'd1);
      check("n2_op1", 32'(rsp_op1), 32'h1234);
      check("n2_op2", 32'(rsp_op2), 32'hBEEF);
      step();
      check("n2_valid_drop", 32'(rsp_valid), 32'd0);
      check("n2_ready_back", 32'(req_ready), 32'd1);
      check("n2_strobes", 32'(strobes - base), 32'd2);

      // One source: single strobe, response in the third cycle, op2 zero
      base = strobes;
      request(2'd1, 3'd5, 3'd3);
      check("n1_issue_addr", 32'(rf_read_addr), 32'd5);
      step();
      check("n1_c2_valid", 32'(rsp_valid), 32'd0);
      step();
      check("n1_c3_valid", 32'(rsp_valid), 32'd1);
      check("n1_op1", 32'(rsp_op1), 32'hBEEF);
      check("n1_op2", 32'(rsp_op2), 32'd0);
      check("n1_strobes", 32'(strobes - base), 32'd1);
      step();

      // No sources: response next cycle, no read strobe
      base = strobes;
      request(2'd0, 3'd3, 3'd5);
      check("n0_valid", 32'(rsp_valid), 32'd1);
      check("n0_op1", 32'(rsp_op1), 32'd0);
      check("n0_op2", 32'(rsp_op2), 32'd0);
      check("n0_rd_en", 32'(rf_read_enable), 32'd0);
      step();
      check("n0_strobes", 32'(strobes - base), 32'd0);
      check("n0_valid_drop", 32'(rsp_valid), 32'd0);

      // nsrc=3 behaves as two sources (operand order swapped)
      request(2'd3, 3'd5, 3'd3);
      step(); step(); step();
      check("n3_valid", 32'(rsp_valid), 32'd1);
      check("n3_op1", 32'(rsp_op1), 32'hBEEF);
      check("n3_op2", 32'(rsp_op2), 32'h1234);
      step();

      // Backpressure: response held stable while rsp_ready is low
      rsp_ready = 1'b0;
      request(2'd1, 3'd3, 3'd0);
      step(); step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_op1", 32'(rsp_op1), 32'h1234);
         check("bp_hold_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(rsp_valid), 32'd0);
      check("bp_release_ready", 32'(req_ready), 32'd1);

      // Reset in ISSUE2 abandons the fetch
      request(2'd2, 3'd3, 3'd5);
      step();
      check("rst_pre_addr", 32'(rf_read_addr), 32'd5);
      base = rsp_seen;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_op1", 32'(rsp_op1), 32'd0);
      check("rst_mid_addr", 32'(rf_read_addr), 32'd0);
      check("rst_mid_rd_en", 32'(rf_read_enable), 32'd0);
      for (int i = 0; i < 5; i++) step();
      check("rst_no_response", 32'(rsp_seen - base), 32'd0);

      // Writeback during capture and while holding the response
      rsp_ready = 1'b0;
      request(2'd2, 3'd3, 3'd5);
      step();
      wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h00AA;
      #1;
      check("wr_port_en", 32'(rf_write_enable), 32'd1);
      check("wr_port_addr", 32'(rf_write_addr), 32'd3);
      check("wr_port_data", 32'(rf_write_data), 32'h00AA);
      step();
      wb_valid = 1'b0;
      step();
      check("byp_cap_valid", 32'(rsp_valid), 32'd1);
      check("byp_cap_op1", 32'(rsp_op1), 32'(EXP_BYP_CAPTURE));
      check("byp_cap_op2", 32'(rsp_op2), 32'hBEEF);
      wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h0055;
      step();
      wb_valid = 1'b0;
      check("byp_hold_valid", 32'(rsp_valid), 32'd1);
      check("byp_hold_op1", 32'(rsp_op1), 32'(EXP_BYP_HOLD));
      check("byp_hold_op2", 32'(rsp_op2), 32'hBEEF);
      rsp_ready = 1'b1;
      step();
      check("byp_done_valid", 32'(rsp_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Initiator side of the 8x16 single-read-port register file interface.
- Accepts one decoded instruction's source-register request (0, 1 or 2 sources) and sequences the reads through the regfile's single read port.
- Captures the operands and presents them to execute with a valid/ready handshake.
- Drives the regfile write port from the writeback stage.

Parameters:
- DATA_W, 16, operand/register width
- ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  decode presents a fetch request
- req_ready  out  1  block can accept a request
- req_nsrc  in  2  number of sources: 0, 1 or 2 (3 treated as 2)
- req_src1  in  ADDR_W  first source register
- req_src2  in  ADDR_W  second source register
- rsp_valid  out  1  operands valid
- rsp_ready  in  1  execute accepts operands
- rsp_op1  out  DATA_W  first operand
- rsp_op2  out  DATA_W  second operand
- rf_read_enable  out  1  regfile read strobe
- rf_read_addr  out  ADDR_W  regfile read address
- rf_read_data  in  DATA_W  regfile read data, valid the cycle after the strobe
- wb_valid  in  1  writeback stage writes a register
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- rf_write_enable  out  1  regfile write strobe
- rf_write_addr  out  ADDR_W  regfile write address
- rf_write_data  out  DATA_W  regfile write data

Behaviour:
- Reset: one clock, clk; reset rst is synchronous and active-high. rst=1 at a posedge forces:
  - state=IDLE
  - rsp_valid=0, rsp_op1=0, rsp_op2=0
  - rf_read_enable=0, rf_read_addr=0
  - latched src/nsrc cleared
- Reset mid-operation abandons any in-flight fetch; no response is produced for it.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready at a posedge; src1, src2 and nsrc are latched then.
- State machine:
  - IDLE: on accept, if nsrc=0 go to RESP with op1=op2=0; otherwise go to ISSUE1.
  - ISSUE1: rf_read_enable=1, rf_read_addr=src1. Next state is ISSUE2 if nsrc=2, else LAST.
  - ISSUE2: rf_read_enable=1, rf_read_addr=src2; capture rf_read_data into op1. Next: LAST.
  - LAST: rf_read_enable=0; capture rf_read_data into op2 if nsrc=2, else into op1. Next: RESP.
  - RESP: rsp_valid=1, operands held stable. On rsp_ready go to IDLE, and rsp_valid drops the next cycle.
- rf_read_enable and rf_read_addr are decoded from state and latched sources; rf_read_addr holds its last value when not reading.
- Unused operand is 0 (op2 for nsrc=1; both for nsrc=0).
- Latency from accept edge to rsp_valid high:
  - nsrc=0: 1 cycle
  - nsrc=1: 3 cycles
  - nsrc=2: 4 cycles
- Throughput: one request per (latency+1) cycles, with no back-to-back overlap.
- Write port: rf_write_enable/addr/data = wb_valid/addr/data combinationally; these signals are independent of the FSM and of reset state.
- src1==src2 is legal and is read twice.

Optional Feature:
- Macro: OPERAND_FETCH_WB_BYPASS_EN.
- Defined:
  - At each capture cycle, if wb_valid && wb_addr equals the register being captured, wb_data is stored instead of rf_read_data.
  - In RESP, a wb hit on a latched source updates the held operand (rsp_opN changes the cycle after).
  - For nsrc=1, only src1 is checked.
- Undefined: operands come only from rf_read_data; writeback has no effect on held operands.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W constants
  - fetch state encoding (IDLE, ISSUE1, ISSUE2, LAST, RESP as a 3-bit enum)
  - nsrc encodings
- No sub-module; the optional bypass compare is a small local function, one instance per operand.

Test Plan:
- Reset regfile with R3=0x1234, R5=0xBEEF. Request nsrc=2, src1=3, src2=5, rsp_ready=1 → rf_read_addr 3 then 5; rsp_valid 4 cycles after accept with op1=0x1234, op2=0xBEEF; rsp_valid high 1 cycle.
- nsrc=1, src1=5 → a single read strobe; rsp_valid after 3 cycles with op1=0xBEEF, op2=0.
- nsrc=0 → no read strobe; rsp_valid 1 cycle after accept with op1=op2=0.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid and operands stable; req_ready=0 throughout; accept completes on the first rsp_ready=1.
- rst pulsed in ISSUE2 → next cycle state IDLE, req_ready=1, rsp_valid=0, rsp_op1=0; no response appears.
- With bypass: src1=3, wb_valid with wb_addr=3, wb_data=0x00AA in ISSUE2 → op1=0x00AA. Then wb writes R3=0x0055 while in RESP → rsp_op1 becomes 0x0055. Without bypass → op1=0x1234 in both cases.
